fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 34 +++
 rtl/fetch_stage_pc_next_mux.sv | 44 ++++
 rtl/fetch_stage.sv | 137 +++++++++++++
 tb/tb_fetch_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions used by the fetch stage: halt/NOP words, pc_src
// encodings, fetch FSM states and the IF/ID pipeline register payload.
package fetch_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] NOP_WORD  = 32'h0000_0000;

    localparam logic [1:0] PCSRC_INC    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_inc;
        logic            valid;
        logic            finish;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{
        instr:  NOP_WORD,
        pc_inc: 32'h0000_0000,
        valid:  1'b0,
        finish: 1'b0
    };

endpackage

// File: rtl/fetch_stage_pc_next_mux.sv
// Combinational next-PC selection.
// Ports:
//   i_pc            current PC (word address)
//   i_pc_src        redirect select (00/11 = PC+1, 01 = branch, 10 = jump)
//   i_branch_target branch target word address
//   i_jump_target   jump target word address
//   o_pc_inc_c      PC+1, wraps modulo 2^32
//   o_pc_next_c     selected next PC
//   o_redirect_c    1 when a branch or jump is selected
module pc_next_mux
    import fetch_stage_pkg::*;
(
    input  logic [XLEN-1:0] i_pc,
    input  logic [1:0]      i_pc_src,
    input  logic [XLEN-1:0] i_branch_target,
    input  logic [XLEN-1:0] i_jump_target,
    output logic [XLEN-1:0] o_pc_inc_c,
    output logic [XLEN-1:0] o_pc_next_c,
    output logic            o_redirect_c
);

    assign o_pc_inc_c = i_pc + XLEN'(1);

    // Encoding 11 is unused and falls through to sequential fetch
    always_comb begin
        o_pc_next_c  = o_pc_inc_c;
        o_redirect_c = 1'b0;
        case (i_pc_src)
            PCSRC_BRANCH: begin
                o_pc_next_c  = i_branch_target;
                o_redirect_c = 1'b1;
            end
            PCSRC_JUMP: begin
                o_pc_next_c  = i_jump_target;
                o_redirect_c = 1'b1;
            end
            default: begin
                o_pc_next_c  = o_pc_inc_c;
                o_redirect_c = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and the
// RUN/DRAIN/HALT fetch FSM that stops fetching after the halt word.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   stall           hold PC and IF/ID (overridden by a redirect)
//   pc_src          redirect select from EX/MEM
//   branch_target   target for pc_src = 01
//   jump_target     target for pc_src = 10
//   imem_addr       current PC to instruction RAM
//   imem_rdata      instruction word for imem_addr (same cycle)
//   if_id_instr     IF/ID instruction
//   if_id_pc_inc    IF/ID PC+1
//   if_id_valid     IF/ID holds a real instruction
//   if_id_finish    IF/ID holds the halt word
//   halted          pipeline drained, fetch stopped until reset
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_inc,
    output logic        if_id_valid,
    output logic        if_id_finish,
    output logic        halted
);

    localparam int unsigned CNT_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES);

    fetch_state_t     r_state;
    fetch_state_t     w_state_nxt;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  w_pc_nxt;
    if_id_t           r_if_id;
    if_id_t           w_if_id_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic [XLEN-1:0]  w_pc_inc;
    logic [XLEN-1:0]  w_pc_target;
    logic             w_redirect;
    logic             w_is_halt;

    pc_next_mux u_pc_next_mux (
        .i_pc            (r_pc),
        .i_pc_src        (pc_src),
        .i_branch_target (branch_target),
        .i_jump_target   (jump_target),
        .o_pc_inc_c      (w_pc_inc),
        .o_pc_next_c     (w_pc_target),
        .o_redirect_c    (w_redirect)
    );

    assign w_is_halt = (imem_rdata == HALT_WORD);

    // State, PC, IF/ID and drain counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_if_id <= IF_ID_BUBBLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_if_id <= w_if_id_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and next-register logic; redirect beats stall, HALT ignores all inputs
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_if_id_nxt = r_if_id;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_RUN: begin
                if (w_redirect) begin
                    w_pc_nxt    = w_pc_target;
                    w_if_id_nxt = IF_ID_BUBBLE;
                end else if (!stall) begin
                    w_if_id_nxt.instr  = imem_rdata;
                    w_if_id_nxt.pc_inc = w_pc_inc;
                    w_if_id_nxt.valid  = 1'b1;
                    w_if_id_nxt.finish = w_is_halt;
                    w_pc_nxt           = w_pc_inc;
                    if (w_is_halt) begin
                        w_state_nxt = ST_DRAIN;
                        w_cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_redirect) begin
                    // Halt word was in a branch shadow: resume fetching at the target
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = w_pc_target;
                    w_if_id_nxt = IF_ID_BUBBLE;
                    w_cnt_nxt   = '0;
                end else if (!stall) begin
                    w_if_id_nxt = IF_ID_BUBBLE;
                    if (r_cnt <= CNT_W'(1)) begin
                        w_state_nxt = ST_HALT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign imem_addr    = r_pc;
    assign if_id_instr  = r_if_id.instr;
    assign if_id_pc_inc = r_if_id.pc_inc;
    assign if_id_valid  = r_if_id.valid;
    assign if_id_finish = r_if_id.finish;
    assign halted       = (r_state == ST_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam int unsigned DRAIN  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [1:0]  pc_src;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_inc;
    logic        if_id_valid;
    logic        if_id_finish;
    logic        halted;

    fetch_stage #(
        .RESET_PC     (RST_PC),
        .DRAIN_CYCLES (DRAIN)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .if_id_instr   (if_id_instr),
        .if_id_pc_inc  (if_id_pc_inc),
        .if_id_valid   (if_id_valid),
        .if_id_finish  (if_id_finish),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pipeline contents described as plain values
    logic [31:0] m_pc, m_instr, m_pcinc;
    logic        m_valid, m_finish;
    int          m_mode;   // 0 fetching, 1 draining, 2 halted
    int          m_left;   // unstalled cycles still to drain

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pcinc;
        logic        valid;
        logic        finish;
        logic        halted;
    } exp_t;

    exp_t q[$];
    exp_t e;

    task automatic model_reset();
        m_pc = RST_PC; m_instr = 0; m_pcinc = 0; m_valid = 0; m_finish = 0;
        m_mode = 0; m_left = 0;
    endtask

    task automatic model_bubble();
        m_instr = 0; m_valid = 0; m_finish = 0;
    endtask

    task automatic model_step(input logic st, input logic [1:0] src,
                              input logic [31:0] bt, input logic [31:0] jt,
                              input logic [31:0] rd);
        if (m_mode == 2) begin
            // halted: nothing changes
        end else if (src == 2'b01 || src == 2'b10) begin
            m_pc = (src == 2'b01) ? bt : jt;
            model_bubble();
            m_mode = 0;
            m_left = 0;
        end else if (st) begin
            // hold
        end else if (m_mode == 0) begin
            m_instr  = rd;
            m_pcinc  = m_pc + 1;
            m_valid  = 1;
            m_finish = (rd == HALT_W);
            m_pc     = m_pc + 1;
            if (rd == HALT_W) begin
                m_mode = 1;
                m_left = DRAIN;
            end
        end else begin
            model_bubble();
            m_left = m_left - 1;
            if (m_left <= 0) m_mode = 2;
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return {4'hA, pc[27:0]};
    endfunction

    // One clock: drive at negedge, queue the expected post-edge view, return at next negedge
    task automatic step(input logic st, input logic [1:0] src,
                        input logic [31:0] bt, input logic [31:0] jt,
                        input logic [31:0] rd);
        exp_t x;
        stall = st; pc_src = src; branch_target = bt; jump_target = jt; imem_rdata = rd;
        model_step(st, src, bt, jt, rd);
        x.addr = m_pc; x.instr = m_instr; x.pcinc = m_pcinc;
        x.valid = m_valid; x.finish = m_finish; x.halted = (m_mode == 2);
        q.push_back(x);
        @(negedge clk);
    endtask

    task automatic free(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 32'h0, 32'h0, word_at(m_pc));
    endtask

    // Asynchronous reset asserted between edges, checked before any clock edge
    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_addr",   imem_addr, RST_PC);
        chk("rst_instr",  if_id_instr, 32'h0);
        chk("rst_pcinc",  if_id_pc_inc, 32'h0);
        chk("rst_valid",  32'(if_id_valid), 32'h0);
        chk("rst_finish", 32'(if_id_finish), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        model_reset();
        stall = 1'b0; pc_src = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare every post-edge output against the scoreboard
    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("imem_addr",    imem_addr, e.addr);
            chk("if_id_instr",  if_id_instr, e.instr);
            chk("if_id_valid",  32'(if_id_valid), 32'(e.valid));
            chk("if_id_finish", 32'(if_id_finish), 32'(e.finish));
            chk("halted",       32'(halted), 32'(e.halted));
            if (e.valid) chk("if_id_pc_inc", if_id_pc_inc, e.pcinc);
        end
    end

    initial begin
        int unstalled;
        int guard;
        logic st;
        logic [1:0] src;
        logic [31:0] rd;

        rst_n = 1'b1; stall = 1'b0; pc_src = 2'b00;
        branch_target = 0; jump_target = 0; imem_rdata = 0;
        model_reset();

        do_reset();
        free(3);                                   // A,B,C at 0,1,2
        free(2);                                   // PC = 5
        step(1'b1, 2'b00, 32'h0, 32'h0, word_at(m_pc));
        step(1'b1, 2'b00, 32'h0, 32'h0, word_at(m_pc));
        free(1);                                   // PC = 6
        free(2);                                   // PC = 8
        step(1'b1, 2'b01, 32'd20, 32'h0, word_at(m_pc));  // branch beats stall
        step(1'b0, 2'b10, 32'h0, 32'd10, word_at(m_pc));  // jump to 10
        step(1'b0, 2'b00, 32'h0, 32'h0, HALT_W);          // halt at 10, PC -> 11

        unstalled = 0;
        guard = 0;
        while (!halted && guard < 100) begin
            st = 1'($urandom_range(0, 1));
            if (!st) unstalled++;
            step(st, 2'b00, 32'h0, 32'h0, $urandom);
            guard++;
        end
        chk("drain_len", 32'(unstalled), 32'(DRAIN));

        for (int i = 0; i < 20; i++)
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom);

        do_reset();                                // mid-HALT
        free(3);                                   // PC = 3
        step(1'b0, 2'b00, 32'h0, 32'h0, HALT_W);   // halt captured
        step(1'b0, 2'b10, 32'h0, 32'd40, word_at(m_pc));
        free(10);

        for (int s = 0; s < 8; s++) begin
            do_reset();
            for (int i = 0; i < 60; i++) begin
                st  = ($urandom_range(0, 3) == 0);
                src = 2'b00;
                if ($urandom_range(0, 6) == 0) src = 2'($urandom_range(1, 2));
                else if ($urandom_range(0, 9) == 0) src = 2'b11;
                rd  = ($urandom_range(0, 15) == 0) ? HALT_W : word_at(m_pc);
                step(st, src, 32'($urandom_range(0, 255)), 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)), rd);
            end
        end

        repeat (2) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
